// File: rtl/pingpong_match_ctrl.sv
// Ping-pong match sequencer: ball position, step timer, hit/miss/fault
// arbitration and scoring. Optional macro PINGPONG_SPEEDUP_EN adds a rally speed-up.
module pingpong_match_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int WIN_SCORE  = 9,
    parameter int HOLD_STEPS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1,
    input  logic       p2,
    input  logic [1:0] speed_sel,
    output logic [7:0] led,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic       serve_turn,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_SERVE = 3'd0,
        S_TO_P2 = 3'd1,
        S_TO_P1 = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } st_t;

    localparam int CW = $clog2(CLK_HZ + 1);
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [3:0]    WIN       = 4'(WIN_SCORE);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    // Step periods per rate, all fixed at elaboration
    localparam logic [CW-1:0] PER1 = CW'(CLK_HZ / 1);
    localparam logic [CW-1:0] PER2 = CW'(CLK_HZ / 2);
    localparam logic [CW-1:0] PER3 = CW'(CLK_HZ / 3);
`ifdef PINGPONG_SPEEDUP_EN
    localparam logic [CW-1:0] PER4 = CW'(CLK_HZ / 4);
    localparam logic [CW-1:0] PER5 = CW'(CLK_HZ / 5);
    localparam logic [CW-1:0] PER6 = CW'(CLK_HZ / 6);
`endif

    function automatic logic [CW-1:0] per_of(input logic [2:0] r);
        case (r)
            3'd2:    per_of = PER2;
            3'd3:    per_of = PER3;
`ifdef PINGPONG_SPEEDUP_EN
            3'd4:    per_of = PER4;
            3'd5:    per_of = PER5;
            3'd6:    per_of = PER6;
`endif
            default: per_of = PER1;
        endcase
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        sat_inc = (s >= WIN) ? s : s + 4'd1;
    endfunction

    st_t           state_q, state_n;
    logic [7:0]    led_q, led_n;
    logic [3:0]    s1_q, s1_n;
    logic [3:0]    s2_q, s2_n;
    logic [1:0]    win_q, win_n;
    logic          srv_q, srv_n;
    logic [HW-1:0] hold_q, hold_n;

    logic          p1_q, p2_q;
    logic          pr1_q, pr2_q;

    logic [CW-1:0] cnt_q, per_q;
    logic          tick;
    logic          tmr_clr;
    logic [2:0]    base_rate;
    logic [2:0]    rate;

    logic          pt1, pt2;

    // Button edge detect, registered once more so the FSM sees a clean pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q  <= 1'b0;
            p2_q  <= 1'b0;
            pr1_q <= 1'b0;
            pr2_q <= 1'b0;
        end else begin
            p1_q  <= p1;
            p2_q  <= p2;
            pr1_q <= p1 & ~p1_q;
            pr2_q <= p2 & ~p2_q;
        end
    end

    assign tick = (cnt_q == per_q - CW'(1));

    assign tmr_clr = (state_n != state_q) &&
                     (state_n inside {S_TO_P1, S_TO_P2, S_POINT});

    always_comb begin
        base_rate = 3'd1;
        if (speed_sel[1]) begin
            base_rate = speed_sel[0] ? 3'd3 : 3'd2;
        end
    end

`ifdef PINGPONG_SPEEDUP_EN
    logic [3:0] hits_q, hits_n;
    logic       hit;

    assign hit = (state_q == S_TO_P2 && state_n == S_TO_P1) ||
                 (state_q == S_TO_P1 && state_n == S_TO_P2);

    // Rally hit count: cleared per serve, saturating at 12
    always_comb begin
        hits_n = hits_q;
        if (state_n == S_SERVE && state_q != S_SERVE) begin
            hits_n = 4'd0;
        end else if (hit && hits_q < 4'd12) begin
            hits_n = hits_q + 4'd1;
        end
    end

    // Hit counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q <= 4'd0;
        end else begin
            hits_q <= hits_n;
        end
    end

    assign rate = base_rate + {1'b0, hits_n[3:2]};
`else
    assign rate = base_rate;
`endif

    // Step timer: period latched at each reload, restarted on rally/point entry
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            per_q <= PER1;
        end else if (tmr_clr || tick) begin
            cnt_q <= '0;
            per_q <= per_of(rate);
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Match state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_SERVE;
            led_q   <= 8'h80;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            win_q   <= 2'b00;
            srv_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_n;
            led_q   <= led_n;
            s1_q    <= s1_n;
            s2_q    <= s2_n;
            win_q   <= win_n;
            srv_q   <= srv_n;
            hold_q  <= hold_n;
        end
    end

    // Next state: serve, ball flight, hit/miss/fault, point hold, game over
    always_comb begin
        state_n = state_q;
        led_n   = led_q;
        s1_n    = s1_q;
        s2_n    = s2_q;
        win_n   = win_q;
        srv_n   = srv_q;
        hold_n  = hold_q;
        pt1     = 1'b0;
        pt2     = 1'b0;

        unique case (state_q)
            S_SERVE: begin
                if (!srv_q && pr1_q) begin
                    state_n = S_TO_P2;
                end else if (srv_q && pr2_q) begin
                    state_n = S_TO_P1;
                end
            end
            S_TO_P2: begin
                if (pr2_q) begin
                    if (led_q[0]) begin
                        state_n = S_TO_P1;
                    end else begin
                        pt1 = 1'b1;
                    end
                end else if (tick) begin
                    if (led_q[0]) begin
                        pt1 = 1'b1;
                    end else begin
                        led_n = led_q >> 1;
                    end
                end
            end
            S_TO_P1: begin
                if (pr1_q) begin
                    if (led_q[7]) begin
                        state_n = S_TO_P2;
                    end else begin
                        pt2 = 1'b1;
                    end
                end else if (tick) begin
                    if (led_q[7]) begin
                        pt2 = 1'b1;
                    end else begin
                        led_n = led_q << 1;
                    end
                end
            end
            S_POINT: begin
                led_n = 8'hFF;
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        if (s1_q == WIN) begin
                            state_n = S_OVER;
                            win_n   = 2'b01;
                            led_n   = 8'hF0;
                        end else if (s2_q == WIN) begin
                            state_n = S_OVER;
                            win_n   = 2'b10;
                            led_n   = 8'h0F;
                        end else begin
                            state_n = S_SERVE;
                            srv_n   = ~srv_q;
                            led_n   = srv_q ? 8'h80 : 8'h01;
                        end
                    end else begin
                        hold_n = hold_q + HW'(1);
                    end
                end
            end
            S_OVER: begin
                state_n = S_OVER;
            end
            default: begin
                state_n = S_SERVE;
                led_n   = 8'h80;
            end
        endcase

        if (pt1) begin
            s1_n = sat_inc(s1_q);
        end
        if (pt2) begin
            s2_n = sat_inc(s2_q);
        end
        if (pt1 || pt2) begin
            state_n = S_POINT;
            led_n   = 8'hFF;
            hold_n  = '0;
        end
    end

    assign led        = led_q;
    assign score1     = s1_q;
    assign score2     = s2_q;
    assign winner     = win_q;
    assign serve_turn = srv_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pingpong_match_ctrl.sv
// Bench for pingpong_match_ctrl: event-time reference model feeding a
// scoreboard of expected output changes, checked by a separate monitor.
module tb_pingpong_match_ctrl;

    localparam int CLK_HZ = 12;
    localparam int WIN    = 3;
    localparam int HOLD   = 2;
`ifdef PINGPONG_SPEEDUP_EN
    localparam int SPD = 1;
`else
    localparam int SPD = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       p1, p2;
    logic [1:0] speed_sel;
    logic [7:0] led;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic       serve_turn;
    logic [2:0] state;

    always #5 clk = ~clk;

    pingpong_match_ctrl #(
        .CLK_HZ(CLK_HZ),
        .WIN_SCORE(WIN),
        .HOLD_STEPS(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .p1(p1),
        .p2(p2),
        .speed_sel(speed_sel),
        .led(led),
        .score1(score1),
        .score2(score2),
        .winner(winner),
        .serve_turn(serve_turn),
        .state(state)
    );

    typedef struct {
        int          cyc;
        logic [21:0] snap;
    } exp_t;

    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int ecnt  = 0;
    bit mon_on = 0;
    bit armed  = 0;

    // Reference model: game state, ball index (7 = P1 end), absolute step time
    int m_st, pos, ms1, ms2, mwin, msrv, mhold, mhits, due;
    bit pv1, pv2, pd1, pd2;
    logic [21:0] mprev;

    function automatic logic [7:0] m_led();
        logic [7:0] v;
        case (m_st)
            0:       v = msrv ? 8'h01 : 8'h80;
            1, 2:    v = 8'(1 << pos);
            3:       v = 8'hFF;
            default: v = (mwin == 1) ? 8'hF0 : 8'h0F;
        endcase
        return v;
    endfunction

    function automatic logic [21:0] m_snap();
        return {3'(m_st), m_led(), 4'(ms1), 4'(ms2), 2'(mwin), 1'(msrv)};
    endfunction

    function automatic logic [21:0] dut_snap();
        return {state, led, score1, score2, winner, serve_turn};
    endfunction

    function automatic int per_of(logic [1:0] sp, int h);
        int r;
        r = sp[1] ? (sp[0] ? 3 : 2) : 1;
        r = r + SPD * (h / 4);
        return CLK_HZ / r;
    endfunction

    task automatic model_step(bit rs, bit i1, bit i2, logic [1:0] sp);
        bit pr1, pr2, tk, ent;
        int sc;
        logic [21:0] s;
        if (rs) begin
            m_st = 0; pos = 7; ms1 = 0; ms2 = 0; mwin = 0; msrv = 0;
            mhold = 0; mhits = 0;
            pv1 = 0; pv2 = 0; pd1 = 0; pd2 = 0;
            due = ecnt + CLK_HZ;
        end else begin
            pr1 = pd1;
            pr2 = pd2;
            pd1 = i1 && !pv1;
            pd2 = i2 && !pv2;
            pv1 = i1;
            pv2 = i2;
            tk  = (ecnt == due);
            ent = 0;
            sc  = 0;
            case (m_st)
                0: begin
                    if (msrv == 0 && pr1) begin
                        m_st = 1; pos = 7; ent = 1;
                    end else if (msrv == 1 && pr2) begin
                        m_st = 2; pos = 0; ent = 1;
                    end
                end
                1: begin
                    if (pr2) begin
                        if (pos == 0) begin
                            m_st = 2; ent = 1;
                            if (mhits < 12) mhits++;
                        end else sc = 1;
                    end else if (tk) begin
                        if (pos == 0) sc = 1;
                        else pos--;
                    end
                end
                2: begin
                    if (pr1) begin
                        if (pos == 7) begin
                            m_st = 1; ent = 1;
                            if (mhits < 12) mhits++;
                        end else sc = 2;
                    end else if (tk) begin
                        if (pos == 7) sc = 2;
                        else pos++;
                    end
                end
                3: begin
                    if (tk) begin
                        mhold++;
                        if (mhold == HOLD) begin
                            if (ms1 == WIN) begin
                                m_st = 4; mwin = 1;
                            end else if (ms2 == WIN) begin
                                m_st = 4; mwin = 2;
                            end else begin
                                m_st = 0; msrv = !msrv; mhits = 0;
                            end
                        end
                    end
                end
                default: ;
            endcase
            if (sc == 1 && ms1 < WIN) ms1++;
            if (sc == 2 && ms2 < WIN) ms2++;
            if (sc != 0) begin
                m_st = 3; mhold = 0; ent = 1;
            end
            if (ent || tk) due = ecnt + per_of(sp, mhits);
        end
        s = m_snap();
        if (armed && s != mprev) begin
            q.push_back('{ecnt, s});
            mprev = s;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        ecnt++;
        model_step(reset, p1, p2, speed_sel);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", nm, got, req);
        end
    endtask

    // Monitor: every visible output change must match the next queued event
    initial begin : monitor
        logic [21:0] prev, cur;
        exp_t e;
        wait (mon_on);
        prev = dut_snap();
        forever begin
            @(negedge clk);
            cur = dut_snap();
            if (cur !== prev) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_change cyc=%0d got=%h",
                             ecnt, cur);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != ecnt || e.snap !== cur) begin
                        fails++;
                        $display("FAIL scoreboard got=%h at cyc %0d required=%h at cyc %0d",
                                 cur, ecnt, e.snap, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    // Stimulus: directed opening, then a randomised player bot
    initial begin : stim
        int gcnt;
        bit w1, w2;
        reset     = 1'b1;
        p1        = 1'b0;
        p2        = 1'b0;
        speed_sel = 2'b00;
        cycle();
        cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_led", 32'(led), 32'h80);
        chk("rst_score1", 32'(score1), 32'd0);
        chk("rst_score2", 32'(score2), 32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_serve", 32'(serve_turn), 32'd0);
        mprev  = m_snap();
        armed  = 1;
        mon_on = 1;

        p2 = 1'b1;
        cycle();
        cycle();
        p2 = 1'b0;
        repeat (5) cycle();
        p1 = 1'b1;
        cycle();
        p1 = 1'b0;
        repeat (140) cycle();

        speed_sel = 2'b11;
        gcnt = 0;
        for (int n = 0; n < 15000; n++) begin
            w1 = 0;
            w2 = 0;
            reset = 1'b0;
            if (m_st == 4) begin
                gcnt++;
                if ($urandom_range(3) == 0) w1 = 1;
                if ($urandom_range(3) == 0) w2 = 1;
                if (gcnt > 40) begin
                    reset = 1'b1;
                    gcnt  = 0;
                end
            end else if (m_st == 0) begin
                if ($urandom_range(5) == 0) begin
                    if (msrv == 1) w2 = 1;
                    else w1 = 1;
                end
            end else if (m_st == 1 && pos == 0) begin
                if ($urandom_range(9) == 0) begin
                    w2 = 1;
                    if ($urandom_range(3) == 0) w1 = 1;
                end
            end else if (m_st == 2 && pos == 7) begin
                if ($urandom_range(9) == 0) begin
                    w1 = 1;
                    if ($urandom_range(3) == 0) w2 = 1;
                end
            end
            if ($urandom_range(149) == 0) w1 = 1;
            if ($urandom_range(149) == 0) w2 = 1;
            if ($urandom_range(2999) == 0) reset = 1'b1;
            if ($urandom_range(199) == 0) speed_sel = 2'($urandom_range(3));
            p1 = w1 ? 1'b1 : (p1 && $urandom_range(1) == 1);
            p2 = w2 ? 1'b1 : (p2 && $urandom_range(1) == 1);
            cycle();
        end

        reset = 1'b0;
        p1    = 1'b0;
        p2    = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_outputs", 32'(dut_snap()), 32'(m_snap()));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
